sram_arbiter: RTL and testbench

Shares the single 2K x 8 asynchronous SRAM on the client board between two requesters. Port 0 is the Nios-side bus bridge and port 1 is the serial receive path that stores incoming characters. The block arbitrates between them round-robin, sequences each SRAM access through a fixed setup/strobe/hold cycle, and owns the tristate data bus and the active-low oe_n/we_n strobes. It sits between the requesters and the board-level SRAM pins.

---
 rtl/sram_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one asynchronous SRAM between two
// requesters. Each access runs a fixed SETUP / ACCESS / HOLD sequence; the
// block owns the tristate data bus and the active-low oe_n / we_n strobes.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   req0/1, we0/1        per-port request and direction (1 = write)
//   addr0/1, wdata0/1    per-port operands, held stable until ack
//   ack0/1               one-cycle completion pulse (HOLD cycle)
//   rdata0/1             read result, updated with ack, held until next read
//   busy                 high whenever the sequencer is not idle
//   sram_addr            SRAM address pins
//   sram_data            SRAM data pins, driven only during writes
//   sram_oe_n, sram_we_n SRAM strobes, active low
module sram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t              state;
  logic                last_srv;
  logic                gnt_port;
  logic                gnt_we;
  logic [DATA_W-1:0]   gnt_wdata;
  logic                drive;

  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // On a tie the port not served last wins; otherwise the lone requester.
  always_comb begin
    pick      = (req0 && req1) ? ~last_srv : req1;
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  // Data bus is driven from a registered enable, so it can never overlap oe_n.
  assign sram_data = drive ? gnt_wdata : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_srv  <= 1'b1;
      gnt_port  <= 1'b0;
      gnt_we    <= 1'b0;
      gnt_wdata <= '0;
      drive     <= 1'b0;
      sram_addr <= '0;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= SETUP;
            gnt_port  <= pick;
            last_srv  <= pick;
            gnt_we    <= sel_we;
            gnt_wdata <= sel_wdata;
            sram_addr <= sel_addr;
            sram_oe_n <= sel_we;
            drive     <= sel_we;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          if (gnt_we) sram_we_n <= 1'b0;
        end
        ACCESS: begin
          state     <= HOLD;
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
          // Read data is sampled on the edge that ends ACCESS, together with ack.
          if (gnt_port) begin
            ack1 <= 1'b1;
            if (!gnt_we) rdata1 <= sram_data;
          end else begin
            ack0 <= 1'b1;
            if (!gnt_we) rdata0 <= sram_data;
          end
        end
        HOLD: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          drive <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a directed table of single
// transactions, hand-written reset / contention / abort sequences, and a
// randomized phase checked against a transaction-timeline reference model.
module tb_sram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic ack0, ack1, busy, sram_oe_n, sram_we_n;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  // Board SRAM: drives the bus while oe_n is low, latches writes on clock
  // edges while we_n is low.
  logic [DW-1:0] sram_mem [2**AW];
  assign sram_data = sram_oe_n ? 'z : sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_data;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] e_rd [2];
  logic [DW-1:0] ref_mem [2**AW];

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic chk_rdata();
    chk("rdata0", rdata0, e_rd[0]);
    chk("rdata1", rdata1, e_rd[1]);
  endtask

  // Entered at the negedge of an IDLE cycle with the request already driven.
  // Checks SETUP, ACCESS, HOLD and the following IDLE cycle; drops req at ack.
  task automatic watch_txn(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("busy", busy, j < 3);
      chk("ack0", ack0, (j == 2) && (p == 0));
      chk("ack1", ack1, (j == 2) && (p == 1));
      chk("oe_n", sram_oe_n, !(!w && j < 2));
      chk("we_n", sram_we_n, !(w && j == 1));
      if (j < 3) chk("sram_addr", sram_addr, a);
      if (w && j < 3) chk("sram_data", sram_data, d);
      if (j == 2 && !w) e_rd[p] = exp_rd;
      chk_rdata();
      if (j == 2) set_port(p, 1'b0, w, a, d);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    e_rd[0] = '0; e_rd[1] = '0;
  endtask

  // Randomized-phase state
  logic          r_req [2];
  logic          r_we  [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wd  [2];
  bit            have_g;
  int            g_cyc, ph;
  logic          g_port, g_we, last, in_txn;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wd, g_rd;
  logic          ack_e [2];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 11'h123, 8'hA5, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 11'h123, 8'hEE, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 11'h7FF, 8'h3C, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 11'h000, 8'h5A, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 11'h7FF, 8'hC3, 8'h3C};
    tbl[5] = '{1'b1, 1'b0, 11'h000, 8'h81, 8'h5A};
    tbl[6] = '{1'b0, 1'b0, 11'h123, 8'h42, 8'hA5};

    // Reset held 2 cycles with both ports requesting
    reset = 1'b1;
    e_rd[0] = '0; e_rd[1] = '0;
    set_port(0, 1'b1, 1'b1, 11'h055, 8'h11);
    set_port(1, 1'b1, 1'b0, 11'h055, 8'h99);
    repeat (2) begin
      @(negedge clk);
      chk("rst_oe_n", sram_oe_n, 1);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_busy", busy, 0);
      chk_rdata();
    end
    reset = 1'b0;
    watch_txn(0, 1'b1, 11'h055, 8'h11, 8'h00);
    watch_txn(1, 1'b0, 11'h055, 8'h99, 8'h11);

    // Directed single transactions
    for (int i = 0; i < 7; i++) begin
      set_port(int'(tbl[i].port), 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      watch_txn(int'(tbl[i].port), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
    end

    // Continuous contention for 20 cycles: port 0 wins first, then alternates
    pulse_reset();
    set_port(0, 1'b1, 1'b1, 11'h7FF, 8'h3C);
    set_port(1, 1'b1, 1'b0, 11'h000, 8'h66);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("cont_ack0", ack0, (j % 8) == 2);
      chk("cont_ack1", ack1, (j % 8) == 6);
      chk("cont_busy", busy, (j % 4) != 3);
      chk("cont_we_n", sram_we_n, (j % 8) != 1);
      chk("cont_oe_n", sram_oe_n, !((j % 8) == 4 || (j % 8) == 5));
      if ((j % 8) == 0) chk("cont_addr0", sram_addr, 11'h7FF);
      if ((j % 8) == 4) chk("cont_addr1", sram_addr, 11'h000);
      if ((j % 8) == 6) e_rd[1] = 8'h5A;
      chk_rdata();
      if (j == 19) begin req0 = 1'b0; req1 = 1'b0; end
    end

    // Reset during ACCESS of a write
    set_port(0, 1'b1, 1'b1, 11'h200, 8'h77);
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_low", sram_we_n, 0);
    reset = 1'b1;
    set_port(0, 1'b0, 1'b1, 11'h200, 8'h77);
    @(negedge clk);
    e_rd[0] = '0; e_rd[1] = '0;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_oe_n", sram_oe_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ack0", ack0, 0);
    chk("abort_ack1", ack1, 0);
    chk_rdata();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy2", busy, 0);
    chk("abort_ack0b", ack0, 0);

    // Port 0 drops req during ACCESS: still acks, no second transaction
    set_port(0, 1'b1, 1'b0, 11'h7FF, 8'h00);
    @(negedge clk);
    chk("drop_busy", busy, 1);
    @(negedge clk);
    chk("drop_oe_n", sram_oe_n, 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("drop_ack0", ack0, 1);
    e_rd[0] = 8'h3C;
    chk_rdata();
    for (int j = 3; j < 7; j++) begin
      @(negedge clk);
      chk("drop_idle_busy", busy, 0);
      chk("drop_idle_ack0", ack0, 0);
    end

    // Randomized traffic against the reference model
    pulse_reset();
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = sram_mem[i];
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
    end
    have_g = 1'b0; g_cyc = 0; last = 1'b1;
    g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0; g_rd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if ((!have_g || cyc >= g_cyc + 4) && (r_req[0] || r_req[1])) begin
        g_port = (r_req[0] && r_req[1]) ? !last : r_req[1];
        last   = g_port;
        have_g = 1'b1;
        g_cyc  = cyc;
        g_we   = r_we[g_port];
        g_addr = r_addr[g_port];
        g_wd   = r_wd[g_port];
        if (g_we) ref_mem[g_addr] = g_wd;
        else      g_rd = ref_mem[g_addr];
      end
      @(negedge clk);
      in_txn = have_g && (cyc <= g_cyc + 2);
      ph = cyc - g_cyc;
      ack_e[0] = in_txn && ph == 2 && g_port == 1'b0;
      ack_e[1] = in_txn && ph == 2 && g_port == 1'b1;
      chk("rnd_busy", busy, in_txn);
      chk("rnd_ack0", ack0, ack_e[0]);
      chk("rnd_ack1", ack1, ack_e[1]);
      chk("rnd_oe_n", sram_oe_n, !(in_txn && !g_we && ph < 2));
      chk("rnd_we_n", sram_we_n, !(in_txn && g_we && ph == 1));
      if (in_txn) chk("rnd_addr", sram_addr, g_addr);
      if (in_txn && g_we) chk("rnd_data", sram_data, g_wd);
      if (in_txn && ph == 2 && !g_we) e_rd[g_port] = g_rd;
      chk_rdata();
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p] || ack_e[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            r_req[p]  = 1'b1;
            r_we[p]   = 1'($urandom_range(0, 1));
            r_addr[p] = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 7));
            r_wd[p]   = 8'($urandom);
          end else begin
            r_req[p] = 1'b0;
          end
        end
        set_port(p, r_req[p], r_we[p], r_addr[p], r_wd[p]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
